// File: rtl/cpu_core_mc.sv
// Multi-cycle 32-bit core: FETCH -> WAIT -> EXEC sequencing, 16-entry register
// file with optional per-register even parity and sticky parity-error halt.
module cpu_core_mc #(
  parameter int          NREGS     = 16,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        err_inject,
  output logic [31:0] pc_value,
  output logic        halted,
  output logic        parity_error,
  output logic        retire,
  output logic [31:0] retire_count
);

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_WAIT  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_HALT  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  localparam logic [4:0] NREGS_W = 5'(NREGS);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_LIL  = 4'h8;
  localparam logic [3:0] OP_LIH  = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_BNE  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t      state_r;
  state_t      state_nx_s;
  logic [31:0] pc_r;
  logic [31:0] pc_nx_s;
  logic [31:0] instr_r;
  logic [31:0] count_r;
  logic        req_valid_r;
  logic        halted_r;
  logic        perr_r;
  logic        retire_r;
  logic [31:0] regs_r [16];
  logic        par_r  [16];

  logic [3:0]  op_s;
  logic [3:0]  rd_s;
  logic [3:0]  rs1_s;
  logic [3:0]  rs2_s;
  logic [15:0] imm_s;
  logic [31:0] sext_s;
  logic [31:0] rs1_val_s;
  logic [31:0] rs2_val_s;
  logic [31:0] alu_s;
  logic        wr_op_s;
  logic        uses_rs2_s;
  logic        rs1_bad_s;
  logic        rs2_bad_s;
  logic        par_fault_s;
  logic        taken_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] br_target_s;
  logic        exec_ok_s;
  logic        wr_en_s;

  function automatic logic even_parity(input logic [31:0] data);
    return ^data;
  endfunction

  // Index 0 and indices at or above NREGS have no storage behind them.
  function automatic logic reg_live(input logic [3:0] idx);
    return (idx != 4'd0) && ({1'b0, idx} < NREGS_W);
  endfunction

  assign op_s        = instr_r[31:28];
  assign rd_s        = instr_r[27:24];
  assign rs1_s       = instr_r[23:20];
  assign rs2_s       = instr_r[19:16];
  assign imm_s       = instr_r[15:0];
  assign sext_s      = {{16{imm_s[15]}}, imm_s};
  assign rs1_val_s   = reg_live(rs1_s) ? regs_r[rs1_s] : 32'd0;
  assign rs2_val_s   = reg_live(rs2_s) ? regs_r[rs2_s] : 32'd0;
  assign pc_plus4_s  = pc_r + 32'd4;
  assign br_target_s = pc_plus4_s + {sext_s[29:0], 2'b00};

  // Operand parity check; rs2 only counts for opcodes that actually read it.
  always_comb begin
    rs1_bad_s  = 1'b0;
    rs2_bad_s  = 1'b0;
    uses_rs2_s = (op_s <= OP_SRL) || (op_s == OP_BEQ) || (op_s == OP_BNE);
    if (PARITY_EN && reg_live(rs1_s)) begin
      rs1_bad_s = par_r[rs1_s] != even_parity(regs_r[rs1_s]);
    end else begin
      rs1_bad_s = 1'b0;
    end
    if (PARITY_EN && reg_live(rs2_s)) begin
      rs2_bad_s = par_r[rs2_s] != even_parity(regs_r[rs2_s]);
    end else begin
      rs2_bad_s = 1'b0;
    end
    par_fault_s = rs1_bad_s | (uses_rs2_s & rs2_bad_s);
  end

  // Result datapath and branch decision.
  always_comb begin
    alu_s   = 32'd0;
    wr_op_s = 1'b0;
    taken_s = 1'b0;
    case (op_s)
      OP_ADD:  begin alu_s = rs1_val_s + rs2_val_s;          wr_op_s = 1'b1; end
      OP_SUB:  begin alu_s = rs1_val_s - rs2_val_s;          wr_op_s = 1'b1; end
      OP_AND:  begin alu_s = rs1_val_s & rs2_val_s;          wr_op_s = 1'b1; end
      OP_OR:   begin alu_s = rs1_val_s | rs2_val_s;          wr_op_s = 1'b1; end
      OP_XOR:  begin alu_s = rs1_val_s ^ rs2_val_s;          wr_op_s = 1'b1; end
      OP_SLL:  begin alu_s = rs1_val_s << rs2_val_s[4:0];    wr_op_s = 1'b1; end
      OP_SRL:  begin alu_s = rs1_val_s >> rs2_val_s[4:0];    wr_op_s = 1'b1; end
      OP_ADDI: begin alu_s = rs1_val_s + sext_s;             wr_op_s = 1'b1; end
      OP_LIL:  begin alu_s = {16'h0000, imm_s};              wr_op_s = 1'b1; end
      OP_LIH:  begin alu_s = {imm_s, rs1_val_s[15:0]};       wr_op_s = 1'b1; end
      OP_BEQ:  taken_s = (rs1_val_s == rs2_val_s);
      OP_BNE:  taken_s = (rs1_val_s != rs2_val_s);
      default: begin
        alu_s   = 32'd0;
        wr_op_s = 1'b0;
        taken_s = 1'b0;
      end
    endcase
  end

  // Sequencer next state, PC update and retire/write enables.
  always_comb begin
    state_nx_s = state_r;
    pc_nx_s    = pc_r;
    exec_ok_s  = 1'b0;
    wr_en_s    = 1'b0;
    case (state_r)
      ST_FETCH: begin
        if (req_valid_r && imem_req_ready) begin
          state_nx_s = ST_WAIT;
        end else begin
          state_nx_s = ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          state_nx_s = ST_EXEC;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_EXEC: begin
        if (par_fault_s) begin
          state_nx_s = ST_ERROR;
        end else begin
          exec_ok_s = 1'b1;
          wr_en_s   = wr_op_s && reg_live(rd_s);
          if (op_s == OP_HALT) begin
            state_nx_s = ST_HALT;
            pc_nx_s    = pc_r;
          end else begin
            state_nx_s = ST_FETCH;
            pc_nx_s    = taken_s ? br_target_s : pc_plus4_s;
          end
        end
      end
      ST_HALT:  state_nx_s = ST_HALT;
      ST_ERROR: state_nx_s = ST_ERROR;
      default:  state_nx_s = ST_FETCH;
    endcase
  end

  // Control state and registered status outputs, all derived from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_FETCH;
      pc_r        <= RESET_PC;
      instr_r     <= 32'd0;
      count_r     <= 32'd0;
      req_valid_r <= 1'b0;
      halted_r    <= 1'b0;
      perr_r      <= 1'b0;
      retire_r    <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      pc_r        <= pc_nx_s;
      req_valid_r <= (state_nx_s == ST_FETCH);
      halted_r    <= (state_nx_s == ST_HALT) || (state_nx_s == ST_ERROR);
      retire_r    <= exec_ok_s;
      if (exec_ok_s) begin
        count_r <= count_r + 32'd1;
      end
      if ((state_r == ST_EXEC) && par_fault_s) begin
        perr_r <= 1'b1;
      end
      if ((state_r == ST_WAIT) && imem_rsp_valid) begin
        instr_r <= imem_rsp_data;
      end
    end
  end

  // Register file with a parity bit per entry; err_inject corrupts the stored bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        regs_r[i] <= 32'd0;
        par_r[i]  <= 1'b0;
      end
    end else if (wr_en_s) begin
      regs_r[rd_s] <= alu_s;
      par_r[rd_s]  <= PARITY_EN ? (even_parity(alu_s) ^ err_inject) : 1'b0;
    end
  end

  assign imem_req_valid = req_valid_r;
  assign imem_addr      = pc_r;
  assign pc_value       = pc_r;
  assign halted         = halted_r;
  assign parity_error   = perr_r;
  assign retire         = retire_r;
  assign retire_count   = count_r;

endmodule
